// File: rtl/wash_sequencer.sv
// Washing machine phase sequencer: IDLE/READY, SOAK/WASH/RINSE/SPIN run phases, PAUSE on open lid, one-cycle DONE.
// Ports: clk, rst_n, start, cancel, lid, mode[1:0] in; state, phase_sel, *_en, busy, paused, done, remaining out.
module wash_sequencer #(
  parameter int CNT_W   = 16,
  parameter int SOAK_T  = 100,
  parameter int WASH_T  = 200,
  parameter int RINSE_T = 150,
  parameter int SPIN_T  = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cancel,
  input  logic             lid,
  input  logic [1:0]       mode,
  output logic [2:0]       state,
  output logic [1:0]       phase_sel,
  output logic             soak_en,
  output logic             wash_en,
  output logic             rinse_en,
  output logic             spin_en,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_SOAK  = 3'd2,
    S_WASH  = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_PAUSE = 3'd6,
    S_DONE  = 3'd7
  } st_t;

  localparam logic [1:0] M_QUICK = 2'b01;
  localparam logic [1:0] M_HEAVY = 2'b11;

  // Counter loads are duration-1 so a phase lasts exactly its duration.
  localparam logic [CNT_W-1:0] L_SOAK  = CNT_W'(SOAK_T - 1);
  localparam logic [CNT_W-1:0] L_WASH  = CNT_W'(WASH_T - 1);
  localparam logic [CNT_W-1:0] L_WASH2 = CNT_W'(2 * WASH_T - 1);
  localparam logic [CNT_W-1:0] L_RINSE = CNT_W'(RINSE_T - 1);
  localparam logic [CNT_W-1:0] L_SPIN  = CNT_W'(SPIN_T - 1);

  st_t              st;
  st_t              saved;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_q;
  logic             rinse_rep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      saved     <= S_SOAK;
      cnt       <= '0;
      mode_q    <= 2'b00;
      rinse_rep <= 1'b0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (start && !lid && !cancel)
            st <= S_READY;
        end
        S_READY: begin
          if (cancel) begin
            st <= S_IDLE;
          end else if (!lid && mode != 2'b00) begin
            mode_q    <= mode;
            rinse_rep <= 1'b0;
            if (mode == M_QUICK) begin
              st  <= S_WASH;
              cnt <= L_WASH;
            end else begin
              st  <= S_SOAK;
              cnt <= L_SOAK;
            end
          end
        end
        S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
          if (cancel) begin
            st  <= S_IDLE;
            cnt <= '0;
          end else if (lid) begin
            st    <= S_PAUSE;
            saved <= st;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (st == S_SOAK) begin
            st  <= S_WASH;
            cnt <= (mode_q == M_HEAVY) ? L_WASH2 : L_WASH;
          end else if (st == S_WASH) begin
            st  <= S_RINSE;
            cnt <= L_RINSE;
          end else if (st == S_RINSE) begin
            // Heavy runs a second rinse before spinning.
            if (mode_q == M_HEAVY && !rinse_rep) begin
              rinse_rep <= 1'b1;
              cnt       <= L_RINSE;
            end else begin
              st  <= S_SPIN;
              cnt <= L_SPIN;
            end
          end else begin
            st  <= S_DONE;
            cnt <= '0;
          end
        end
        S_PAUSE: begin
          if (cancel) begin
            st  <= S_IDLE;
            cnt <= '0;
          end else if (start && !lid) begin
            st <= saved;
          end
        end
        S_DONE: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    phase_sel = 2'b00;
    unique case (st)
      S_WASH:  phase_sel = 2'b01;
      S_RINSE: phase_sel = 2'b10;
      S_SPIN:  phase_sel = 2'b11;
      default: phase_sel = 2'b00;
    endcase
  end

  assign state     = st;
  assign soak_en   = (st == S_SOAK);
  assign wash_en   = (st == S_WASH);
  assign rinse_en  = (st == S_RINSE);
  assign spin_en   = (st == S_SPIN);
  assign paused    = (st == S_PAUSE);
  assign done      = (st == S_DONE);
  assign busy      = soak_en | wash_en | rinse_en | spin_en | paused;
  assign remaining = busy ? cnt : '0;

endmodule

// File: tb/tb_wash_sequencer.sv
// Testbench for wash_sequencer: vector table driven per cycle, expectations queued and checked after each edge.
// Covers all modes, pause/resume, lid at expiry, cancel priority, mode 00 hold and async reset.
module tb_wash_sequencer;

  localparam int CW = 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READY = 3'd1;
  localparam logic [2:0] SOAK  = 3'd2;
  localparam logic [2:0] WASH  = 3'd3;
  localparam logic [2:0] RINSE = 3'd4;
  localparam logic [2:0] SPIN  = 3'd5;
  localparam logic [2:0] PAUSE = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  localparam logic [1:0] MQ = 2'b01;
  localparam logic [1:0] MN = 2'b10;
  localparam logic [1:0] MH = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cancel = 1'b0;
  logic          lid = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [2:0]    state;
  logic [1:0]    phase_sel;
  logic          soak_en, wash_en, rinse_en, spin_en;
  logic          busy, paused, done;
  logic [CW-1:0] remaining;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       s;
    logic       c;
    logic       l;
    logic [1:0] m;
    logic [2:0] st;
    int         rem;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    int         rem;
    int         idx;
  } exp_t;

  vec_t tbl[$];
  exp_t scb[$];

  wash_sequencer #(
    .CNT_W(CW), .SOAK_T(4), .WASH_T(6), .RINSE_T(5), .SPIN_T(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
    .lid(lid), .mode(mode), .state(state), .phase_sel(phase_sel),
    .soak_en(soak_en), .wash_en(wash_en), .rinse_en(rinse_en),
    .spin_en(spin_en), .busy(busy), .paused(paused), .done(done),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  // Expected decoded outputs for a given state:
  // {phase_sel[1:0], soak, wash, rinse, spin, busy, paused, done}
  function automatic logic [8:0] decode(logic [2:0] st);
    logic [1:0] ps;
    ps = 2'b00;
    if (st == WASH)  ps = 2'b01;
    if (st == RINSE) ps = 2'b10;
    if (st == SPIN)  ps = 2'b11;
    return {ps, st == SOAK, st == WASH, st == RINSE, st == SPIN,
            (st >= SOAK && st <= PAUSE), st == PAUSE, st == DONE};
  endfunction

  task automatic check(string nm, logic [2:0] st, int rem);
    logic [8:0] got;
    logic [8:0] want;
    got  = {phase_sel, soak_en, wash_en, rinse_en, spin_en,
            busy, paused, done};
    want = decode(st);
    total++;
    if (state !== st || remaining !== CW'(rem) || got !== want) begin
      bad++;
      $display("FAIL %s: got state=%0d rem=%0d outs=%b, want state=%0d rem=%0d outs=%b",
               nm, state, remaining, got, st, rem, want);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (scb.size() > 0) begin
      e = scb.pop_front();
      check($sformatf("vec%0d", e.idx), e.st, e.rem);
    end
  end

  task automatic v(logic s, logic c, logic l, logic [1:0] m,
                   logic [2:0] st, int rem);
    vec_t x;
    x.s = s; x.c = c; x.l = l; x.m = m; x.st = st; x.rem = rem;
    tbl.push_back(x);
  endtask

  // A phase with quiet inputs, counting down n-1 .. 0.
  task automatic run(logic [1:0] m, logic [2:0] st, int n);
    for (int k = n - 1; k >= 0; k--) v(1'b0, 1'b0, 1'b0, m, st, k);
  endtask

  int vidx = 0;

  task automatic apply_table();
    exp_t e;
    foreach (tbl[i]) begin
      @(negedge clk);
      start  = tbl[i].s;
      cancel = tbl[i].c;
      lid    = tbl[i].l;
      mode   = tbl[i].m;
      e.st   = tbl[i].st;
      e.rem  = tbl[i].rem;
      e.idx  = vidx;
      vidx++;
      scb.push_back(e);
    end
    tbl.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (scb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (scb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d, want 0", scb.size());
      scb.delete();
    end
    start = 0; cancel = 0; lid = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_hold", IDLE, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset", IDLE, 0);

    // lid open blocks start in IDLE
    v(1, 0, 1, MN, IDLE, 0);
    // normal
    v(1, 0, 0, MN, READY, 0);
    run(MN, SOAK, 4); run(MN, WASH, 6); run(MN, RINSE, 5); run(MN, SPIN, 3);
    v(0, 0, 0, MN, DONE, 0);
    v(0, 0, 0, MN, IDLE, 0);
    // quick, mode input changed to heavy after latching
    v(1, 0, 0, MQ, READY, 0);
    v(0, 0, 0, MQ, WASH, 5);
    run(MH, WASH, 5); run(MH, RINSE, 5); run(MH, SPIN, 3);
    v(0, 0, 0, MH, DONE, 0);
    v(0, 0, 0, MH, IDLE, 0);
    // heavy
    v(1, 0, 0, MH, READY, 0);
    run(MH, SOAK, 4); run(MH, WASH, 12);
    run(MH, RINSE, 5); run(MH, RINSE, 5); run(MH, SPIN, 3);
    v(0, 0, 0, MH, DONE, 0);
    v(0, 0, 0, MH, IDLE, 0);
    // lid in WASH at remaining 3, held 10 cycles, resume
    v(1, 0, 0, MQ, READY, 0);
    v(0, 0, 0, MQ, WASH, 5);
    v(0, 0, 0, MQ, WASH, 4);
    v(0, 0, 0, MQ, WASH, 3);
    for (int k = 0; k < 10; k++) v(k == 5, 0, 1, MQ, PAUSE, 3);
    v(1, 0, 0, MQ, WASH, 3);
    v(0, 0, 0, MQ, WASH, 2);
    v(0, 0, 0, MQ, WASH, 1);
    v(0, 0, 0, MQ, WASH, 0);
    v(0, 0, 0, MQ, RINSE, 4);
    v(0, 1, 0, MQ, IDLE, 0);
    // lid at expiry in RINSE
    v(1, 0, 0, MQ, READY, 0);
    run(MQ, WASH, 6); run(MQ, RINSE, 5);
    v(0, 0, 1, MQ, PAUSE, 0);
    v(0, 0, 0, MQ, PAUSE, 0);
    v(1, 0, 0, MQ, RINSE, 0);
    run(MQ, SPIN, 3);
    // cancel at SPIN expiry: no DONE
    v(0, 1, 0, MQ, IDLE, 0);
    v(0, 0, 0, MQ, IDLE, 0);
    // mode 00 holds READY, cancel returns IDLE
    v(1, 0, 0, 2'b00, READY, 0);
    v(0, 0, 0, 2'b00, READY, 0);
    v(0, 0, 0, 2'b00, READY, 0);
    v(0, 1, 0, 2'b00, IDLE, 0);
    // cancel beats lid in PAUSE
    v(1, 0, 0, MN, READY, 0);
    v(0, 0, 0, MN, SOAK, 3);
    v(0, 0, 1, MN, PAUSE, 3);
    v(0, 1, 1, MN, IDLE, 0);
    // into SOAK for async reset
    v(1, 0, 0, MN, READY, 0);
    v(0, 0, 0, MN, SOAK, 3);
    v(0, 0, 0, MN, SOAK, 2);
    apply_table();
    drain();

    // async reset mid-SOAK, observed before the next edge
    #2 rst_n = 1'b0;
    #1 check("async_reset", IDLE, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v(0, 0, 0, MN, IDLE, 0);
    v(1, 0, 0, MN, READY, 0);
    v(0, 0, 0, MN, SOAK, 3);
    apply_table();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, phase timer width.
REQ-002 SHALL have parameter SOAK_T, default 100, soak duration in cycles (>=1).
REQ-003 SHALL have parameter WASH_T, default 200, base wash duration in cycles (>=1).
REQ-004 SHALL have parameter RINSE_T, default 150, rinse duration in cycles (>=1).
REQ-005 SHALL have parameter SPIN_T, default 100, spin duration in cycles (>=1).
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports start, cancel, lid, each input, 1: start request, abort request, lid open (1 = open).
REQ-009 SHALL have port mode, input, 2: 00 invalid, 01 quick, 10 normal, 11 heavy.
REQ-010 SHALL have port state, output, 3: IDLE=0, READY=1, SOAK=2, WASH=3, RINSE=4, SPIN=5, PAUSE=6, DONE=7.
REQ-011 SHALL have port phase_sel, output, 2: SOAK 00, WASH 01, RINSE 10, SPIN 11, else 00.
REQ-012 SHALL have ports soak_en, wash_en, rinse_en, spin_en, output, 1, each high only while in its state.
REQ-013 SHALL have ports busy, paused, done, each output, 1.
REQ-014 SHALL have port remaining, output, CNT_W, current phase timer value.

Function
REQ-015 SHALL give event priority cancel > lid open > timer expiry > start in every state.
REQ-016 SHALL move IDLE->READY on start=1, lid=0, cancel=0.
REQ-017 SHALL move READY->first phase the next cycle if mode!=00, lid=0, cancel=0; SHALL remain in READY on mode=00; SHALL return to IDLE on cancel.
REQ-018 SHALL latch mode on the READY->run transition; mode changes during a cycle SHALL have no effect.
REQ-019 SHALL run phases as follows: quick WASH, RINSE, SPIN; normal SOAK, WASH, RINSE, SPIN; heavy SOAK, WASH (2*WASH_T), RINSE, RINSE, SPIN.
REQ-020 SHALL load the down-counter with duration-1 on entry to each phase, including a repeated RINSE; each phase SHALL last exactly its duration in cycles when not paused.
REQ-021 SHALL advance to the next phase on the edge where counter==0 and no pause or cancel is pending.
REQ-022 SHALL, when lid=1 in any run phase, enter PAUSE on the next edge, save the phase, freeze the counter and deassert all *_en.
REQ-023 SHALL return from PAUSE to the saved phase, counter unchanged, when start=1, lid=0, cancel=0; PAUSE->IDLE on cancel.
REQ-024 SHALL pause, not advance, when lid opens while counter==0; on resume the phase SHALL end after one cycle.
REQ-025 SHALL enter DONE after the final SPIN; DONE SHALL last one cycle with done=1, then go to IDLE unconditionally.
REQ-026 SHALL return any run phase to IDLE on cancel=1 with counter cleared and done not asserted.
REQ-027 SHALL assert busy in SOAK, WASH, RINSE, SPIN and PAUSE, and assert paused only in PAUSE.
REQ-028 SHALL drive remaining as the counter in run phases and PAUSE, and 0 in IDLE, READY and DONE.
REQ-029 SHALL require 2*WASH_T <= 2^CNT_W; the counter SHALL never wrap.
REQ-030 SHALL drive all outputs from registered state and counter only, with no combinational input-to-output path.

Reset
REQ-031 SHALL, on rst_n=0, immediately set state=IDLE, counter=0, latched mode=00, saved phase=SOAK and rinse repeat flag=0, independent of clk.
REQ-032 SHALL, on reset mid-cycle, leave all outputs at 0 and restart from IDLE when rst_n releases.

Verification (SOAK_T=4, WASH_T=6, RINSE_T=5, SPIN_T=3, CNT_W=8)
REQ-033 SHALL cover: normal mode, start pulse -> READY 1 cycle, SOAK 4, WASH 6, RINSE 5, SPIN 3, DONE 1 with done=1, then IDLE.
REQ-034 SHALL cover: quick mode -> no SOAK, WASH first; heavy mode -> WASH 12 cycles and two RINSE phases of 5 cycles each.
REQ-035 SHALL cover: lid=1 in WASH at remaining=3 -> PAUSE, remaining held at 3 for 10 cycles; start with lid=0 -> WASH resumes and ends 4 cycles later.
REQ-036 SHALL cover: lid=1 and counter==0 on the same cycle in RINSE -> PAUSE, not SPIN; after resume RINSE lasts 1 cycle.
REQ-037 SHALL cover: cancel=1 coincident with timer expiry in SPIN -> IDLE next cycle, done stays 0; mode=00 in READY -> READY held.
REQ-038 SHALL cover: rst_n=0 asynchronously mid-SOAK -> state=0 and all outputs 0 before the next clk edge.
